divider_line_sequencer: RTL
===========================

Name: divider_line_sequencer

Overview:
Sits between the AFU host-memory interface and the fixed-latency `divider` core.
- Accepts one 512-bit cache line holding 8 packed (a, b) operand pairs.
- Issues the pairs to the divider one per cycle and tracks each in flight with a latency-matched tag pipeline.
- Packs the 8 quotients into one 512-bit result line for the write path.
- Replaces the single-pair, fixed-wait sequencing with a streamed, line-wide one.

Parameters:
- DATA_LEN, 32, operand and result width in bits.
- LINE_BITS, 512, cache-line width in bits.
- DIV_LATENCY, 5, cycles from operands presented on div_a/div_b to the matching quotient on div_result (must be ≥1).
- Derived, not overridable: NUM_PAIRS = LINE_BITS/(2*DATA_LEN) = 8.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand line valid
- in_ready  output  1  sequencer can accept a line
- in_data  input  LINE_BITS  pair i: a = [2i*DATA_LEN +: DATA_LEN], b = [(2i+1)*DATA_LEN +: DATA_LEN]
- div_a  output  DATA_LEN  dividend to divider core (registered)
- div_b  output  DATA_LEN  divisor to divider core (registered)
- div_result  input  DATA_LEN  quotient from divider core
- out_valid  output  1  result line valid
- out_ready  input  1  consumer accepts result line
- out_data  output  LINE_BITS  result i in [i*DATA_LEN +: DATA_LEN]; bits above NUM_PAIRS*DATA_LEN are zero
- out_dbz_mask  output  NUM_PAIRS  bit i set if pair i had b == 0
- busy  output  1  high in every state except IDLE
- lines_done  output  32  count of result lines handed off, wraps at 2^32

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0.
  - div_a, div_b, out_data, out_dbz_mask, lines_done all zero; busy=0.
  - Tag pipeline cleared; state IDLE.
- Reset asserted mid-operation aborts the line. No partial result is ever emitted.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_data, clear the result register and mask, set idx=0, go to ISSUE.
  - ISSUE: each cycle, register div_a/div_b ← pair idx and push tag {valid=1, idx, dbz=(b==0)} into the DIV_LATENCY-deep tag pipe. Increment idx. After pair NUM_PAIRS-1 is issued, go to DRAIN.
  - DRAIN: no issue. div_a/div_b are registered to zero. Wait until the tag for pair NUM_PAIRS-1 exits the pipe and its result is captured, then go to OUTPUT.
  - OUTPUT: out_valid=1. out_data and out_dbz_mask are held stable until out_ready. On the cycle out_valid && out_ready: increment lines_done, go to IDLE. out_valid drops the next cycle.
- Outside ISSUE, div_a/div_b are always zero.
- Timing contract:
  - A pair registered onto div_a/div_b is visible during cycle n.
  - Its tag leaves the pipe during cycle n+DIV_LATENCY.
  - div_result is sampled in that same cycle and written to lane tag.idx.
- Divide-by-zero: if tag.dbz is set, the lane is written as all-ones (regardless of div_result) and mask bit idx is set.
- Timing for one line:
  - Acceptance to first issue: 1 cycle.
  - Issue span: NUM_PAIRS consecutive cycles.
  - out_valid rises the cycle after the last capture, i.e. DIV_LATENCY+1 cycles after the last issue cycle.
- in_valid while not in IDLE is ignored; the upstream must hold it.
- Only one line is in flight at a time.
- Tag pipe advances every cycle; bubbles carry valid=0 and are never captured.

Test Plan:
- Line with pairs (100,7),(81,9),(1,1),(0,5),(0xFFFFFFFF,2),(50,50),(7,100),(1000,10) → out_data lanes 14,9,1,0,0x7FFFFFFF,1,0,100; out_dbz_mask=0x00; upper 256 bits zero; lines_done=1.
- Pair 3 = (42,0), others (10,2) → lane 3 = 0xFFFFFFFF, mask=0x08, lanes ≠ 3 equal 5.
- Cycle check with DIV_LATENCY=5: in_valid accepted at cycle 0 → div_a/div_b show pairs 0..7 in cycles 1..8, zero at 9; out_valid rises at cycle 14.
- out_ready held low 10 cycles after out_valid → out_data/mask stable, in_ready=0, a second in_valid is ignored. Release → handshake completes, in_ready=1 next cycle.
- reset asserted during ISSUE (after pair 3) → next cycle all outputs at reset values. A fresh line afterwards produces a correct result with no stale lanes.
- Back-to-back 3 lines with out_ready=1 → lines_done=3, each line's results correct, no lane mixing between lines.

Source files
------------

// File: rtl/divider_line_sequencer.sv
// Streams the 8 operand pairs of one cache line into a fixed-latency divider and
// gathers the quotients into a single result line, flagging divide-by-zero lanes.
module divider_line_sequencer #(
  parameter int unsigned  DATA_LEN    = 32,
  parameter int unsigned  LINE_BITS   = 512,
  parameter int unsigned  DIV_LATENCY = 5,
  localparam int unsigned NUM_PAIRS   = LINE_BITS / (2 * DATA_LEN),
  localparam int unsigned IdxW        = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LINE_BITS-1:0] in_data,
  output logic [DATA_LEN-1:0]  div_a,
  output logic [DATA_LEN-1:0]  div_b,
  input  logic [DATA_LEN-1:0]  div_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LINE_BITS-1:0] out_data,
  output logic [NUM_PAIRS-1:0] out_dbz_mask,
  output logic                 busy,
  output logic [31:0]          lines_done
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PAIRS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOutput} state_e;

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
    logic            dbz;
  } tag_t;

  state_e                 state_q;
  logic [LINE_BITS-1:0]   line_q;
  logic [IdxW-1:0]        idx_q;
  tag_t                   iss_tag_q;
  tag_t                   tag_pipe_q [DIV_LATENCY];
  tag_t                   tag_out;
  logic [DATA_LEN-1:0]    res_q [NUM_PAIRS];
  logic [NUM_PAIRS-1:0]   mask_q;
  logic [DATA_LEN-1:0]    div_a_q, div_b_q;
  logic                   in_ready_q, busy_q, out_valid_q;
  logic [31:0]            lines_done_q;
  logic [DATA_LEN-1:0]    pair_a [NUM_PAIRS];
  logic [DATA_LEN-1:0]    pair_b [NUM_PAIRS];
  logic [DATA_LEN-1:0]    in_a0, in_b0;

  always_comb begin
    for (int i = 0; i < NUM_PAIRS; i++) begin
      pair_a[i] = line_q[2*i*DATA_LEN +: DATA_LEN];
      pair_b[i] = line_q[(2*i+1)*DATA_LEN +: DATA_LEN];
    end
  end

  assign in_a0   = in_data[DATA_LEN-1:0];
  assign in_b0   = in_data[2*DATA_LEN-1:DATA_LEN];
  // iss_tag_q lines up with div_a/div_b, so the last stage is DIV_LATENCY cycles later.
  assign tag_out = tag_pipe_q[DIV_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      line_q       <= '0;
      idx_q        <= '0;
      iss_tag_q    <= '0;
      for (int k = 0; k < DIV_LATENCY; k++) tag_pipe_q[k] <= '0;
      for (int i = 0; i < NUM_PAIRS; i++) res_q[i] <= '0;
      mask_q       <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      lines_done_q <= '0;
    end else begin
      tag_pipe_q[0] <= iss_tag_q;
      for (int k = 1; k < DIV_LATENCY; k++) tag_pipe_q[k] <= tag_pipe_q[k-1];
      iss_tag_q <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;

      if (tag_out.valid) begin
        res_q[tag_out.idx] <= tag_out.dbz ? '1 : div_result;
        if (tag_out.dbz) mask_q[tag_out.idx] <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Pair 0 goes out on the acceptance edge to save a cycle of issue latency.
            line_q     <= in_data;
            for (int i = 0; i < NUM_PAIRS; i++) res_q[i] <= '0;
            mask_q     <= '0;
            div_a_q    <= in_a0;
            div_b_q    <= in_b0;
            iss_tag_q  <= '{valid: 1'b1, idx: '0, dbz: (in_b0 == '0)};
            idx_q      <= IdxW'(1);
            state_q    <= (NUM_PAIRS == 1) ? StDrain : StIssue;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StIssue: begin
          div_a_q   <= pair_a[idx_q];
          div_b_q   <= pair_b[idx_q];
          iss_tag_q <= '{valid: 1'b1, idx: idx_q, dbz: (pair_b[idx_q] == '0)};
          idx_q     <= idx_q + 1'b1;
          if (idx_q == LastIdx) state_q <= StDrain;
        end
        StDrain: begin
          if (tag_out.valid && (tag_out.idx == LastIdx)) begin
            state_q     <= StOutput;
            out_valid_q <= 1'b1;
          end
        end
        StOutput: begin
          if (out_ready) begin
            lines_done_q <= lines_done_q + 32'd1;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_PAIRS; i++) out_data[i*DATA_LEN +: DATA_LEN] = res_q[i];
  end

  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_dbz_mask = mask_q;
  assign lines_done   = lines_done_q;

endmodule
